// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive-side frame dispatcher.
package eth_rx_pkg;

  localparam logic [15:0] ETH_ARP  = 16'h0806;
  localparam logic [15:0] ETH_IPV4 = 16'h0800;

  localparam logic DEST_ARP  = 1'b0;
  localparam logic DEST_IPV4 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CLASSIFY,
    S_DRAIN,
    S_REARM,
    S_WAIT_LOW
  } rx_state_e;

  typedef struct packed {
    logic fwd;
    logic dest;
  } route_t;

  // Unknown EtherTypes come back with fwd = 0, i.e. drop mode.
  function automatic route_t classify_etype(input logic [15:0] etype);
    route_t r;
    r.fwd  = 1'b0;
    r.dest = DEST_ARP;
    if (etype == ETH_ARP) begin
      r.fwd  = 1'b1;
      r.dest = DEST_ARP;
    end else if (etype == ETH_IPV4) begin
      r.fwd  = 1'b1;
      r.dest = DEST_IPV4;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_ready_sync.sv
// Two-flop synchronizer bringing the 50 MHz frame-complete level into clk_100_mhz.
module rx_ready_sync (
  input  logic clk_100_mhz,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_frame_dispatcher.sv
// Drains one received frame from the RMII FIFO, routes it by EtherType, then re-arms the receiver.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for synchronized rx_ready
// S_SETTLE   | letting the FIFO empty flag cross domains
// S_CLASSIFY | latch forward/drop route and destination from EtherType
// S_DRAIN    | read FIFO words, present or discard them
// S_REARM    | rx_rearm_n held low
// S_WAIT_LOW | waiting for rx_ready to drop before accepting a new frame
module rx_frame_dispatcher
  import eth_rx_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int REARM_CYCLES  = 4,
  parameter int MAX_WORDS     = 400
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [15:0] rx_protocol_type,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        rx_rearm_n,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tdest,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);
  localparam logic [15:0] REARM_LD  = 16'(REARM_CYCLES - 1);
  localparam logic [8:0]  MAX_W     = 9'(MAX_WORDS);

  logic rx_ready_s;

  rx_ready_sync u_rx_ready_sync (
    .clk_100_mhz (clk_100_mhz),
    .rst         (rst),
    .d           (rx_ready),
    .q           (rx_ready_s)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] rearm_cnt_q, rearm_cnt_d;
  logic        rearm_n_q, rearm_n_d;
  logic        fwd_q, fwd_d;
  logic        tdest_q, tdest_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        pend_q, pend_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        busy_q, busy_d;

  logic   rd_en;
  logic   capture;
  logic   sink_free;
  logic   hs;
  logic   at_max;
  route_t route;

  // FIFO dout holds its word until the next read, so a pending word can wait
  // out backpressure without a skid buffer.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    rearm_cnt_d = rearm_cnt_q;
    rearm_n_d   = rearm_n_q;
    fwd_d       = fwd_q;
    tdest_d     = tdest_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pend_d      = pend_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    rd_en       = 1'b0;
    capture     = 1'b0;
    route       = classify_etype(rx_protocol_type);
    at_max      = (word_cnt_q == MAX_W);
    hs          = tvalid_q && m_tready;
    sink_free   = !fwd_q || at_max || !tvalid_q || m_tready;

    unique case (state_q)
      S_IDLE: begin
        if (rx_ready_s) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (settle_q == 16'd0) state_d = S_CLASSIFY;
        else                   settle_d = settle_q - 16'd1;
      end
      S_CLASSIFY: begin
        fwd_d      = route.fwd;
        tdest_d    = route.dest;
        word_cnt_d = 9'd0;
        pend_d     = 1'b0;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        rd_en   = !fifo_empty && sink_free;
        capture = pend_q && sink_free;
        pend_d  = rd_en || (pend_q && !capture);
        if (hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        // Captures past MAX_WORDS are consumed but never presented.
        if (capture && !at_max) begin
          word_cnt_d = word_cnt_q + 9'd1;
          if (fwd_q) begin
            tdata_d  = fifo_dout;
            tvalid_d = 1'b1;
            tlast_d  = fifo_empty || ((word_cnt_q + 9'd1) == MAX_W);
          end
        end
        if (fifo_empty && !pend_q && (!tvalid_q || m_tready)) begin
          state_d     = S_REARM;
          rearm_cnt_d = REARM_LD;
          rearm_n_d   = 1'b0;
          if (!fwd_q)                  drop_cnt_d  = drop_cnt_q + 16'd1;
          else if (word_cnt_q != 9'd0) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_REARM: begin
        if (rearm_cnt_q == 16'd0) begin
          state_d   = S_WAIT_LOW;
          rearm_n_d = 1'b1;
        end else begin
          rearm_cnt_d = rearm_cnt_q - 16'd1;
        end
      end
      S_WAIT_LOW: begin
        if (!rx_ready_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= 16'd0;
      rearm_cnt_q <= 16'd0;
      rearm_n_q   <= 1'b1;
      fwd_q       <= 1'b0;
      tdest_q     <= 1'b0;
      tdata_q     <= 32'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      pend_q      <= 1'b0;
      word_cnt_q  <= 9'd0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      rearm_cnt_q <= rearm_cnt_d;
      rearm_n_q   <= rearm_n_d;
      fwd_q       <= fwd_d;
      tdest_q     <= tdest_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      pend_q      <= pend_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign fifo_rd_en  = rd_en;
  assign rx_rearm_n  = rearm_n_q;
  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign m_tdest     = tdest_q;
  assign busy        = busy_q;
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule
